// File: rtl/seg_display_arbiter.sv
// Shares a 4-digit active-low 7-segment display between two frame requesters.
// Scans digits with anti-ghost blanking and swaps owner/frame only at frame boundaries.
module seg_display_arbiter #(
    parameter int N               = 7,
    parameter int REFRESH_DIV     = 50_000,
    parameter int BLANK_CYC       = 16,
    parameter int MIN_HOLD_FRAMES = 4,
    parameter int CW              = 16
) (
    input  logic           CLK1,
    input  logic           arst,
    input  logic [1:0]     req,
    input  logic [4*N-1:0] seg_in0,
    input  logic [4*N-1:0] seg_in1,
    output logic [1:0]     gnt,
    output logic [0:N-1]   seg,
    output logic [3:0]     an,
    output logic           frame_done
);

    localparam int HW = $clog2(MIN_HOLD_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);
    localparam logic [HW-1:0]  HOLD_THR  = HW'(MIN_HOLD_FRAMES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(MIN_HOLD_FRAMES);
    localparam logic [N-1:0]   SEG_OFF   = {N{1'b1}};
    localparam logic [4*N-1:0] FRAME_OFF = {(4*N){1'b1}};

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_e;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     digit_q, digit_d;
    state_e         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [4*N-1:0] frame_buf_q, frame_buf_d;
    logic [0:N-1]   seg_q, seg_d;
    logic [3:0]     an_q, an_d;
    logic           fd_q, fd_d;
    logic           tick_s, boundary_s;
    logic [N-1:0]   field_s;
    logic [3:0]     an_code_s;

    assign tick_s     = (cnt_q == CNT_LAST);
    assign boundary_s = tick_s && (digit_q == 2'd3);

    // Slot counter and digit index.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (tick_s) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            digit_d = digit_q;
        end
    end

    // Arbiter next state, hold counter and frame latch, all gated by the frame boundary.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        frame_buf_d = frame_buf_q;
        if (boundary_s) begin
            case (state_q)
                ST_IDLE, ST_OWN0: begin
                    if (req[0]) begin
                        state_d = ST_OWN0;
                    end else if (req[1]) begin
                        state_d = ST_OWN1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    if (!req[1]) begin
                        state_d = req[0] ? ST_OWN0 : ST_IDLE;
                    end else if (req[0] && (hold_q >= HOLD_THR)) begin
                        state_d = ST_OWN0;
                    end else begin
                        state_d = ST_OWN1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_d != state_q) begin
                hold_d = '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end else begin
                hold_d = hold_q;
            end

            case (state_d)
                ST_OWN0: frame_buf_d = seg_in0;
                ST_OWN1: frame_buf_d = seg_in1;
                default: frame_buf_d = FRAME_OFF;
            endcase
        end else begin
            state_d     = state_q;
            hold_d      = hold_q;
            frame_buf_d = frame_buf_q;
        end
    end

    // Digit field select and anode decode for the pin registers.
    always_comb begin
        case (digit_q)
            2'd0: begin field_s = frame_buf_q[4*N-1 -: N]; an_code_s = 4'b0111; end
            2'd1: begin field_s = frame_buf_q[3*N-1 -: N]; an_code_s = 4'b1011; end
            2'd2: begin field_s = frame_buf_q[2*N-1 -: N]; an_code_s = 4'b1101; end
            default: begin field_s = frame_buf_q[N-1:0]; an_code_s = 4'b1110; end
        endcase
        seg_d = field_s;
        an_d  = 4'b1111;
        if (state_q == ST_IDLE) begin
            seg_d = SEG_OFF;
            an_d  = 4'b1111;
        end else if (cnt_q < BLANK_END) begin
            seg_d = field_s;
            an_d  = 4'b1111;
        end else begin
            seg_d = field_s;
            an_d  = an_code_s;
        end
        fd_d = boundary_s;
    end

    // State and output registers.
    always_ff @(posedge CLK1 or posedge arst) begin
        if (arst) begin
            cnt_q       <= '0;
            digit_q     <= 2'd0;
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            frame_buf_q <= FRAME_OFF;
            seg_q       <= SEG_OFF;
            an_q        <= 4'b1111;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            frame_buf_q <= frame_buf_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign gnt        = state_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: scenario tasks plus a frame-level reference model
// that derives the display from elapsed cycles and the ownership rules.
module tb_seg_display_arbiter;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int MH = 2;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        arst;
    logic [1:0]  req;
    logic [27:0] seg_in0, seg_in1;
    logic [1:0]  gnt;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          m_t, m_owner, m_hold;
    logic [6:0]  m_frame [4];
    logic [0:6]  exp_seg;
    logic [3:0]  exp_an;
    logic [1:0]  exp_gnt;
    logic        exp_fd;

    seg_display_arbiter #(
        .N(7), .REFRESH_DIV(RD), .BLANK_CYC(BC), .MIN_HOLD_FRAMES(MH), .CW(4)
    ) dut (
        .CLK1(clk), .arst(arst), .req(req), .seg_in0(seg_in0), .seg_in1(seg_in1),
        .gnt(gnt), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_t = 0; m_owner = 0; m_hold = 0;
        for (int d = 0; d < 4; d++) m_frame[d] = 7'h7f;
        exp_seg = 7'h7f; exp_an = 4'hf; exp_gnt = 2'b00; exp_fd = 1'b0;
    endtask

    // Expected pins after this edge come from the pre-edge scan position and frame.
    task automatic model_step();
        int slot, dig, nxt;
        logic [3:0]  onehot;
        logic [27:0] src;
        if (arst) begin
            model_reset();
        end else begin
            slot = m_t % RD;
            dig  = (m_t / RD) % 4;
            onehot = 4'b1000 >> dig;
            if (m_owner == 0) begin
                exp_seg = 7'h7f; exp_an = 4'hf;
            end else begin
                exp_seg = m_frame[dig];
                exp_an  = (slot < BC) ? 4'hf : ~onehot;
            end
            exp_fd = (m_t % FR == FR - 1);
            if (exp_fd) begin
                if (m_owner == 2 && req[1]) nxt = (req[0] && m_hold + 1 >= MH) ? 1 : 2;
                else nxt = req[0] ? 1 : (req[1] ? 2 : 0);
                m_hold  = (nxt == m_owner) ? m_hold + 1 : 0;
                m_owner = nxt;
                src = (nxt == 1) ? seg_in0 : (nxt == 2) ? seg_in1 : 28'hfff_ffff;
                for (int d = 0; d < 4; d++) m_frame[d] = src[27-7*d -: 7];
            end
            exp_gnt = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            m_t++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b1; req = 2'b00; seg_in0 = $urandom; seg_in1 = $urandom;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, seg, an, frame_done} !== {2'b00, 7'h7f, 4'hf, 1'b0}) begin
            errors++; $display("FAIL reset_init got=%h exp=%h", {gnt, seg, an, frame_done}, {2'b00, 7'h7f, 4'hf, 1'b0});
        end
        arst = 1'b0; req = 2'b01; seg_in0 = $urandom;
        repeat (45) begin
            cycle();
            checks++;
            if ({gnt, seg, an, frame_done} !== {exp_gnt, exp_seg, exp_an, exp_fd}) begin
                errors++; $display("FAIL reset_pre t=%0d got=%h exp=%h", m_t, {gnt, seg, an, frame_done}, {exp_gnt, exp_seg, exp_an, exp_fd});
            end
        end
        #2 arst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({gnt, seg, an, frame_done} !== {2'b00, 7'h7f, 4'hf, 1'b0}) begin
            errors++; $display("FAIL reset_async got=%h exp=%h", {gnt, seg, an, frame_done}, {2'b00, 7'h7f, 4'hf, 1'b0});
        end
        repeat (3) begin
            cycle();
            checks++;
            if ({gnt, seg, an, frame_done} !== {2'b00, 7'h7f, 4'hf, 1'b0}) begin
                errors++; $display("FAIL reset_held got=%h exp=%h", {gnt, seg, an, frame_done}, {2'b00, 7'h7f, 4'hf, 1'b0});
            end
        end
        arst = 1'b0; req = 2'b00;
        repeat (3 * FR) begin
            cycle();
            checks++;
            if (an !== 4'hf || gnt !== 2'b00 || {gnt, seg, an, frame_done} !== {exp_gnt, exp_seg, exp_an, exp_fd}) begin
                errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", m_t, {gnt, seg, an, frame_done}, {exp_gnt, exp_seg, exp_an, exp_fd});
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_exp;
        logic [3:0] onehot;
        seg_in1 = 28'h387_0E1C;
        req = 2'b10;
        do begin
            cycle();
            checks++;
            if ({gnt, seg, an, frame_done} !== {exp_gnt, exp_seg, exp_an, exp_fd}) begin
                errors++; $display("FAIL scan_model t=%0d got=%h exp=%h", m_t, {gnt, seg, an, frame_done}, {exp_gnt, exp_seg, exp_an, exp_fd});
            end
        end while (m_t % FR != 0);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL scan_gnt got=%b exp=10", gnt); end
        cycle();
        for (int i = 0; i < FR; i++) begin
            onehot = 4'b1000 >> (i / RD);
            an_exp = (i % RD < BC) ? 4'hf : ~onehot;
            checks++;
            if (an !== an_exp || seg !== 7'b0011100) begin
                errors++; $display("FAIL scan_slot i=%0d got an=%b seg=%b exp an=%b seg=0011100", i, an, seg, an_exp);
            end
            cycle();
        end
    endtask

    task automatic test_preempt();
        logic [27:0] s0;
        req = 2'b00;
        do cycle(); while (m_t % FR != 0);
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL preempt_idle got=%b exp=00", gnt); end
        req = 2'b10;
        do cycle(); while (m_t % FR != 0);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL preempt_b0 got=%b exp=10", gnt); end
        s0 = $urandom; seg_in0 = s0; req = 2'b11;
        for (int b = 1; b <= 2; b++) begin
            do begin
                cycle();
                checks++;
                if ({gnt, seg, an, frame_done} !== {exp_gnt, exp_seg, exp_an, exp_fd}) begin
                    errors++; $display("FAIL preempt_model t=%0d got=%h exp=%h", m_t, {gnt, seg, an, frame_done}, {exp_gnt, exp_seg, exp_an, exp_fd});
                end
            end while (m_t % FR != 0);
            checks++;
            if (gnt !== ((b == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL preempt_b%0d got=%b exp=%b", b, gnt, (b == 1) ? 2'b10 : 2'b01);
            end
        end
        repeat (3) cycle();
        checks++;
        if (seg !== s0[27:21]) begin errors++; $display("FAIL preempt_frame got=%b exp=%b", seg, s0[27:21]); end
    endtask

    task automatic test_tearing();
        logic [27:0] old_f, new_f;
        logic [6:0]  want;
        int pos;
        old_f = $urandom; seg_in1 = old_f; req = 2'b10;
        do cycle(); while (m_t % FR != 0);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL tear_gnt got=%b exp=10", gnt); end
        repeat (RD) cycle();
        new_f = ~old_f; seg_in1 = new_f;
        for (int k = 1; k <= FR; k++) begin
            cycle();
            pos = RD + k - 1;
            want = (pos < FR) ? old_f[27-7*(pos/RD) -: 7] : new_f[27:21];
            checks++;
            if (seg !== want || {gnt, seg, an, frame_done} !== {exp_gnt, exp_seg, exp_an, exp_fd}) begin
                errors++; $display("FAIL tear_seg k=%0d got=%b exp=%b", k, seg, want);
            end
        end
    endtask

    task automatic test_release();
        req = 2'b01;
        do cycle(); while (m_t % FR != 0);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL rel_own0 got=%b exp=01", gnt); end
        req = 2'b11;
        do cycle(); while (m_t % FR != 0);
        repeat (13) cycle();
        req = 2'b10;
        while (m_t % FR != 0) begin
            checks++;
            if (gnt !== 2'b01) begin errors++; $display("FAIL rel_keep t=%0d got=%b exp=01", m_t, gnt); end
            cycle();
        end
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL rel_own1 got=%b exp=10", gnt); end
        req = 2'b00;
        do cycle(); while (m_t % FR != 0);
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL rel_idle got=%b exp=00", gnt); end
        cycle();
        for (int i = 0; i < FR; i++) begin
            checks++;
            if (an !== 4'hf || seg !== 7'h7f) begin
                errors++; $display("FAIL rel_blank i=%0d got an=%b seg=%b exp an=1111 seg=1111111", i, an, seg);
            end
            cycle();
        end
    endtask

    task automatic test_frame_done();
        int pulses, last, prev;
        req = 2'b01; seg_in0 = $urandom;
        repeat ($urandom_range(0, 31)) cycle();
        pulses = 0; last = -1; prev = 0;
        for (int i = 0; i < 3 * FR; i++) begin
            cycle();
            checks++;
            if (frame_done !== exp_fd || (frame_done && prev)) begin
                errors++; $display("FAIL fd_pulse i=%0d got=%b exp=%b", i, frame_done, exp_fd);
            end
            if (frame_done) begin
                checks++;
                if (last >= 0 && i - last != FR) begin
                    errors++; $display("FAIL fd_spacing got=%0d exp=%0d", i - last, FR);
                end
                last = i; pulses++;
            end
            prev = frame_done;
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL fd_count got=%0d exp=3", pulses); end
        arst = 1'b1; model_reset();
        repeat (40) begin
            cycle();
            checks++;
            if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_in_reset got=%b exp=0", frame_done); end
        end
        arst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20 * FR; i++) begin
            if ($urandom_range(0, 15) == 0) req = 2'($urandom);
            if ($urandom_range(0, 7) == 0) seg_in0 = $urandom;
            if ($urandom_range(0, 7) == 0) seg_in1 = $urandom;
            cycle();
            checks++;
            if ({gnt, seg, an, frame_done} !== {exp_gnt, exp_seg, exp_an, exp_fd}) begin
                errors++; $display("FAIL random t=%0d got=%h exp=%h", m_t, {gnt, seg, an, frame_done}, {exp_gnt, exp_seg, exp_an, exp_fd});
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_preempt();
        test_tearing();
        test_release();
        test_frame_done();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
